// File: rtl/hpu_part_stage_sched.sv
// Stage scheduler for the 3-part partitioned GF64 NTT datapath.
// Optional perf counters: define HPU_PART_SCHED_PERF_EN.
module hpu_part_stage_sched #(
  parameter int S          = 8,
  parameter int DELTA      = 3,
  parameter int BEAT_NB    = 4,
  parameter int BATCH_ID_W = 4,
  parameter int STG_W      = $clog2(2*S)
) (
  input  logic                  clk,
  input  logic                  s_rst,
  input  logic                  batch_vld,
  output logic                  batch_rdy,
  input  logic [BATCH_ID_W-1:0] batch_id,
  output logic                  cmd_vld,
  input  logic                  cmd_rdy,
  output logic [1:0]            cmd_seg,
  output logic [STG_W-1:0]      cmd_stage,
  output logic                  cmd_pp,
  output logic [BATCH_ID_W-1:0] cmd_bid,
  output logic                  cmd_first,
  output logic                  cmd_last,
  input  logic [1:0]            pp_release,
  output logic                  done_vld,
  output logic [BATCH_ID_W-1:0] done_bid,
  output logic                  busy
`ifdef HPU_PART_SCHED_PERF_EN
  ,
  output logic [31:0]           perf_stall_cnt,
  output logic [31:0]           perf_pp_wait_cnt
`endif
);

  localparam int BW = (BEAT_NB > 1) ? $clog2(BEAT_NB) : 1;

  localparam logic [STG_W-1:0] G_LAST = STG_W'(2*S-1);
  localparam logic [STG_W-1:0] G_M1   = STG_W'(DELTA+1);
  localparam logic [STG_W-1:0] G_M2   = STG_W'(2*S-DELTA-1);
  localparam logic [STG_W-1:0] G_S    = STG_W'(S);
  localparam logic [STG_W-1:0] G_S1   = STG_W'(S-1);
  localparam logic [BW-1:0]    B_LAST = BW'(BEAT_NB-1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    WAIT_PP,
    DONE
  } state_t;

  state_t                  state_q, state_d;
  logic [STG_W-1:0]        g_q, g_d;
  logic [BW-1:0]           beat_q, beat_d;
  logic [BATCH_ID_W-1:0]   bid_q, bid_d;
  logic                    bank_q, bank_d;
  logic [1:0]              ppb_q, ppb_d;

  logic                    fire;
  logic                    last_beat;
  logic                    last_all;
  logic [STG_W-1:0]        g_inc;
  logic [1:0]              pp_set;
  logic [1:0]              seg_w;
  logic [STG_W-1:0]        stage_w;

  assign fire      = (state_q == RUN) && cmd_rdy;
  assign last_beat = (beat_q == B_LAST);
  assign last_all  = last_beat && (g_q == G_LAST);
  assign g_inc     = g_q + 1'b1;

  always_comb begin
    state_d = state_q;
    g_d     = g_q;
    beat_d  = beat_q;
    bid_d   = bid_q;
    bank_d  = bank_q;
    unique case (state_q)
      IDLE: begin
        if (batch_vld) begin
          bid_d   = batch_id;
          g_d     = '0;
          beat_d  = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        if (fire) begin
          if (last_all) begin
            state_d = DONE;
          end else if (!last_beat) begin
            beat_d = beat_q + 1'b1;
          end else begin
            beat_d = '0;
            g_d    = g_inc;
            if ((g_inc == G_M1) && ppb_q[bank_q])
              state_d = WAIT_PP;
          end
        end
      end
      WAIT_PP: begin
        if (!ppb_q[bank_q])
          state_d = RUN;
      end
      DONE: begin
        bank_d  = ~bank_q;
        g_d     = '0;
        beat_d  = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // A set on the first MID1 fire overrides a same-cycle release.
  always_comb begin
    pp_set = 2'b00;
    if (fire && (g_q == G_M1) && (beat_q == '0))
      pp_set[bank_q] = 1'b1;
    ppb_d = (ppb_q & ~pp_release) | pp_set;
  end

  always_ff @(posedge clk) begin
    if (s_rst) begin
      state_q <= IDLE;
      g_q     <= '0;
      beat_q  <= '0;
      bid_q   <= '0;
      bank_q  <= 1'b0;
      ppb_q   <= 2'b00;
    end else begin
      state_q <= state_d;
      g_q     <= g_d;
      beat_q  <= beat_d;
      bid_q   <= bid_d;
      bank_q  <= bank_d;
      ppb_q   <= ppb_d;
    end
  end

  always_comb begin
    seg_w = 2'd2;
    if (g_q < G_M1)
      seg_w = 2'd0;
    else if (g_q < G_M2)
      seg_w = 2'd1;
    stage_w = (g_q < G_S) ? (G_S1 - g_q) : g_q;
  end

  // Command fields read zero whenever no beat is offered.
  always_comb begin
    cmd_vld   = (state_q == RUN);
    cmd_seg   = cmd_vld ? seg_w : 2'd0;
    cmd_stage = cmd_vld ? stage_w : '0;
    cmd_pp    = cmd_vld && (seg_w == 2'd1) && bank_q;
    cmd_bid   = cmd_vld ? bid_q : '0;
    cmd_first = cmd_vld && (g_q == '0) && (beat_q == '0);
    cmd_last  = cmd_vld && last_all;
    batch_rdy = (state_q == IDLE);
    done_vld  = (state_q == DONE);
    done_bid  = done_vld ? bid_q : '0;
    busy      = (state_q != IDLE);
  end

`ifdef HPU_PART_SCHED_PERF_EN
  logic [31:0] stall_q, stall_d;
  logic [31:0] wait_q, wait_d;

  always_comb begin
    stall_d = stall_q;
    wait_d  = wait_q;
    if (cmd_vld && !cmd_rdy && (stall_q != 32'hFFFF_FFFF))
      stall_d = stall_q + 32'd1;
    if ((state_q == WAIT_PP) && (wait_q != 32'hFFFF_FFFF))
      wait_d = wait_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (s_rst) begin
      stall_q <= '0;
      wait_q  <= '0;
    end else begin
      stall_q <= stall_d;
      wait_q  <= wait_d;
    end
  end

  assign perf_stall_cnt   = stall_q;
  assign perf_pp_wait_cnt = wait_q;
`endif

endmodule

// File: tb/tb_hpu_part_stage_sched.sv
// Directed bench for hpu_part_stage_sched: default build plus a
// second instance with S=4, DELTA=2, BEAT_NB=1.
module tb_hpu_part_stage_sched;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       s_rst;
  logic       batch_vld;
  logic       batch_rdy;
  logic [3:0] batch_id;
  logic       cmd_vld;
  logic       cmd_rdy;
  logic [1:0] cmd_seg;
  logic [3:0] cmd_stage;
  logic       cmd_pp;
  logic [3:0] cmd_bid;
  logic       cmd_first;
  logic       cmd_last;
  logic [1:0] pp_release;
  logic       done_vld;
  logic [3:0] done_bid;
  logic       busy;
`ifdef HPU_PART_SCHED_PERF_EN
  logic [31:0] perf_stall_cnt;
  logic [31:0] perf_pp_wait_cnt;
`endif

  logic       b_batch_vld;
  logic       b_batch_rdy;
  logic [3:0] b_batch_id;
  logic       b_cmd_vld;
  logic [1:0] b_cmd_seg;
  logic [2:0] b_cmd_stage;
  logic       b_cmd_pp;
  logic [3:0] b_cmd_bid;
  logic       b_cmd_first;
  logic       b_cmd_last;
  logic       b_done_vld;
  logic [3:0] b_done_bid;
  logic       b_busy;
`ifdef HPU_PART_SCHED_PERF_EN
  logic [31:0] b_perf_stall_cnt;
  logic [31:0] b_perf_pp_wait_cnt;
`endif

  hpu_part_stage_sched dut (
    .clk        (clk),
    .s_rst      (s_rst),
    .batch_vld  (batch_vld),
    .batch_rdy  (batch_rdy),
    .batch_id   (batch_id),
    .cmd_vld    (cmd_vld),
    .cmd_rdy    (cmd_rdy),
    .cmd_seg    (cmd_seg),
    .cmd_stage  (cmd_stage),
    .cmd_pp     (cmd_pp),
    .cmd_bid    (cmd_bid),
    .cmd_first  (cmd_first),
    .cmd_last   (cmd_last),
    .pp_release (pp_release),
    .done_vld   (done_vld),
    .done_bid   (done_bid),
    .busy       (busy)
`ifdef HPU_PART_SCHED_PERF_EN
    ,
    .perf_stall_cnt   (perf_stall_cnt),
    .perf_pp_wait_cnt (perf_pp_wait_cnt)
`endif
  );

  hpu_part_stage_sched #(
    .S       (4),
    .DELTA   (2),
    .BEAT_NB (1)
  ) dut_b (
    .clk        (clk),
    .s_rst      (s_rst),
    .batch_vld  (b_batch_vld),
    .batch_rdy  (b_batch_rdy),
    .batch_id   (b_batch_id),
    .cmd_vld    (b_cmd_vld),
    .cmd_rdy    (1'b1),
    .cmd_seg    (b_cmd_seg),
    .cmd_stage  (b_cmd_stage),
    .cmd_pp     (b_cmd_pp),
    .cmd_bid    (b_cmd_bid),
    .cmd_first  (b_cmd_first),
    .cmd_last   (b_cmd_last),
    .pp_release (2'b00),
    .done_vld   (b_done_vld),
    .done_bid   (b_done_bid),
    .busy       (b_busy)
`ifdef HPU_PART_SCHED_PERF_EN
    ,
    .perf_stall_cnt   (b_perf_stall_cnt),
    .perf_pp_wait_cnt (b_perf_pp_wait_cnt)
`endif
  );

  typedef struct {
    logic       rdy;
    logic       vld;
    logic [1:0] seg;
    logic [3:0] stage;
    logic       first;
    logic       last;
  } vec_t;

  int   n_tests = 0;
  int   n_fail  = 0;
  vec_t nom[64];
  vec_t bvec[8];

  int stage_tab[16] = '{7, 6, 5, 4, 3, 2, 1, 0, 8, 9, 10, 11, 12, 13, 14, 15};
  int seg_tab[16]   = '{0, 0, 0, 0, 1, 1, 1, 1, 1, 1, 1, 1, 2, 2, 2, 2};
  int b_stage[8]    = '{3, 2, 1, 0, 4, 5, 6, 7};
  int b_seg[8]      = '{0, 0, 0, 1, 1, 2, 2, 2};

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [13:0] pack_a();
    return {cmd_vld, cmd_seg, cmd_stage, cmd_pp, cmd_bid, cmd_first, cmd_last};
  endfunction

  function automatic logic [13:0] exp_beat(input int k, input int bank,
                                           input logic [3:0] bid);
    logic pp;
    pp = (nom[k].seg == 2'd1) ? bank[0] : 1'b0;
    return {1'b1, nom[k].seg, nom[k].stage, pp, bid, nom[k].first, nom[k].last};
  endfunction

  task automatic accept_a(input logic [3:0] bid);
    chk("accept_rdy", batch_rdy, 1);
    batch_id  = bid;
    batch_vld = 1'b1;
    step();
    batch_vld = 1'b0;
  endtask

  task automatic run_beats(input int bank, input int k0, input int k1,
                           input logic [3:0] bid);
    for (int k = k0; k < k1; k++) begin
      chk($sformatf("beat%0d_b%0d", k, bid), pack_a(), exp_beat(k, bank, bid));
      step();
    end
  endtask

  task automatic wait_done_a(input logic [3:0] bid);
    int n;
    n = 0;
    while (!done_vld && n < 10) begin
      step();
      n++;
    end
    chk($sformatf("done_vld_b%0d", bid), done_vld, 1);
    chk($sformatf("done_bid_b%0d", bid), done_bid, bid);
    step();
  endtask

  initial begin
    int k;
    int cyc;
    logic rdy;

    for (int i = 0; i < 64; i++) begin
      nom[i].rdy   = 1'b1;
      nom[i].vld   = 1'b1;
      nom[i].seg   = 2'(seg_tab[i/4]);
      nom[i].stage = 4'(stage_tab[i/4]);
      nom[i].first = (i == 0);
      nom[i].last  = (i == 63);
    end
    for (int i = 0; i < 8; i++) begin
      bvec[i].rdy   = 1'b1;
      bvec[i].vld   = 1'b1;
      bvec[i].seg   = 2'(b_seg[i]);
      bvec[i].stage = 4'(b_stage[i]);
      bvec[i].first = (i == 0);
      bvec[i].last  = (i == 7);
    end

    s_rst       = 1'b1;
    batch_vld   = 1'b0;
    batch_id    = '0;
    cmd_rdy     = 1'b1;
    pp_release  = 2'b00;
    b_batch_vld = 1'b0;
    b_batch_id  = '0;
    step();
    step();
    chk("rst_batch_rdy", batch_rdy, 1);
    chk("rst_cmd", pack_a(), 0);
    chk("rst_done", {done_vld, done_bid}, 0);
    chk("rst_busy", busy, 0);
    s_rst = 1'b0;
    step();

    // nominal, id 5, bank 0
    accept_a(4'd5);
    for (int i = 0; i < 64; i++) begin
      cmd_rdy = nom[i].rdy;
      chk($sformatf("nom_beat%0d", i), pack_a(), exp_beat(i, 0, 4'd5));
      step();
    end
    chk("nom_done_vld", done_vld, 1);
    chk("nom_done_bid", done_bid, 5);
    chk("nom_rdy_low", batch_rdy, 0);
    step();
    chk("nom_rdy_back", batch_rdy, 1);
    chk("nom_done_pulse", done_vld, 0);

    // backpressure, id 9, bank 1
    accept_a(4'd9);
    k   = 0;
    cyc = 0;
    rdy = 1'b1;
    while (k < 64 && cyc < 300) begin
      cmd_rdy = rdy;
      chk($sformatf("bp_beat%0d", k), pack_a(), exp_beat(k, 1, 4'd9));
      if (rdy) k++;
      rdy = ~rdy;
      step();
      cyc++;
    end
    cmd_rdy = 1'b1;
    chk("bp_count", k, 64);
    chk("bp_done_vld", done_vld, 1);
    chk("bp_done_bid", done_bid, 9);
`ifdef HPU_PART_SCHED_PERF_EN
    chk("perf_stall", perf_stall_cnt, 63);
`endif
    step();

    // bank 0 still busy: 16 MID0 beats then WAIT_PP
    accept_a(4'd3);
    run_beats(0, 0, 16, 4'd3);
    for (int i = 0; i < 3; i++) begin
      chk("pp_wait_vld", cmd_vld, 0);
      chk("pp_wait_busy", busy, 1);
      step();
    end
    pp_release = 2'b01;
    step();
    pp_release = 2'b00;
    chk("pp_r1_vld", cmd_vld, 0);
    step();
    chk("pp_r2_beat", pack_a(), exp_beat(16, 0, 4'd3));
    chk("pp_r2_fields", {cmd_seg, cmd_stage, cmd_pp}, {2'd1, 4'd3, 1'b0});
    pp_release = 2'b01;
    step();
    pp_release = 2'b00;
    run_beats(0, 17, 64, 4'd3);
    wait_done_a(4'd3);
`ifdef HPU_PART_SCHED_PERF_EN
    chk("perf_wait", perf_pp_wait_cnt, 5);
`endif

    // free bank 1, run id 4 without wait
    pp_release = 2'b10;
    step();
    pp_release = 2'b00;
    accept_a(4'd4);
    run_beats(1, 0, 64, 4'd4);
    wait_done_a(4'd4);

    // bank 0 flag survived the same-cycle release
    accept_a(4'd6);
    run_beats(0, 0, 16, 4'd6);
    chk("setwins_vld", cmd_vld, 0);
    step();
    chk("setwins_vld2", cmd_vld, 0);
    s_rst = 1'b1;
    step();
    s_rst = 1'b0;
    chk("rst_wait_vld", cmd_vld, 0);
    chk("rst_wait_rdy", batch_rdy, 1);
    chk("rst_wait_busy", busy, 0);
    chk("rst_wait_done", done_vld, 0);

    // reset after beat 20
    accept_a(4'd7);
    run_beats(0, 0, 21, 4'd7);
    s_rst = 1'b1;
    step();
    s_rst = 1'b0;
    chk("rst_mid_cmd", pack_a(), 0);
    chk("rst_mid_rdy", batch_rdy, 1);
    chk("rst_mid_done", {done_vld, done_bid}, 0);
`ifdef HPU_PART_SCHED_PERF_EN
    chk("rst_perf", perf_stall_cnt | perf_pp_wait_cnt, 0);
`endif
    accept_a(4'd8);
    chk("restart_stage", cmd_stage, 7);
    chk("restart_first", cmd_first, 1);
    run_beats(0, 0, 64, 4'd8);
    wait_done_a(4'd8);

    // small config: S=4, DELTA=2, BEAT_NB=1
    chk("b_rdy", b_batch_rdy, 1);
    b_batch_id  = 4'd2;
    b_batch_vld = 1'b1;
    step();
    b_batch_vld = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("b_beat%0d", i),
          {b_cmd_vld, b_cmd_seg, b_cmd_stage, b_cmd_pp, b_cmd_bid,
           b_cmd_first, b_cmd_last},
          {bvec[i].vld, bvec[i].seg, bvec[i].stage[2:0], 1'b0, 4'd2,
           bvec[i].first, bvec[i].last});
      step();
    end
    chk("b_done", {b_done_vld, b_done_bid, b_busy}, {1'b1, 4'd2, 1'b1});
    step();
    chk("b_idle", {b_batch_rdy, b_busy}, {1'b1, 1'b0});

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/hpu_part_stage_sched.md
# hpu_part_stage_sched

Stage scheduler for the 3-part partitioned GF64 NTT datapath. It accepts one batch at a time and walks it through the 2·S global NTT steps: forward then return. For each step it issues BEAT_NB command beats tagged with segment (MID0 / MID1 / MID2), stage index and ping-pong bank. It also blocks entry into the ping-pong MID1 segment until that batch's bank has been released downstream.

## Interface
Parameters:
- S, 8: NTT stages per direction; 2·S global steps per batch.
- DELTA, 3: outward/return segment depth is DELTA+1 steps. Constraint: DELTA ≤ S-2, so MID1 is non-empty.
- BEAT_NB, 4: command beats per step, ≥1.
- BATCH_ID_W, 4: batch id width.
- STG_W: stage index width, = $clog2(2·S).

Ports:
- clk  in  1  clock.
- s_rst  in  1  reset: synchronous, active-high.
- batch_vld  in  1  batch request.
- batch_rdy  out  1  scheduler can accept a batch.
- batch_id  in  BATCH_ID_W  id of the requested batch.
- cmd_vld  out  1  command beat valid.
- cmd_rdy  in  1  datapath accepts beat.
- cmd_seg  out  2  segment: 0=MID0, 1=MID1, 2=MID2.
- cmd_stage  out  STG_W  stage index.
- cmd_pp  out  1  MID1 ping-pong bank; 0 outside MID1.
- cmd_bid  out  BATCH_ID_W  batch id.
- cmd_first  out  1  first beat of the batch.
- cmd_last  out  1  last beat of the batch.
- pp_release  in  2  one-hot pulse per bank: downstream has freed that MID1 bank.
- done_vld  out  1  one-cycle pulse: batch fully issued.
- done_bid  out  BATCH_ID_W  id of the completed batch.
- busy  out  1  FSM not in IDLE.

## Operation
- FSM states: IDLE, RUN, WAIT_PP, DONE.
- Registers:
  - g: step counter, 0..2S-1.
  - beat: 0..BEAT_NB-1.
  - bid: latched batch id.
  - bank_ptr: bank for the current batch.
  - pp_busy[1:0]: per-bank busy flags.
- IDLE:
  - batch_rdy=1.
  - On batch_vld: latch batch_id, set g=0 and beat=0, go to RUN.
- RUN:
  - cmd_vld=1. A beat fires when cmd_vld && cmd_rdy.
  - All cmd_* fields hold stable while cmd_vld && !cmd_rdy.
  - On fire:
    - If beat<BEAT_NB-1: beat++.
    - Otherwise: beat=0, g++.
    - If the new g=DELTA+1 and pp_busy[bank_ptr]=1: go to WAIT_PP.
    - If the fired beat was the last one (g=2S-1, beat=BEAT_NB-1): go to DONE.
- WAIT_PP:
  - cmd_vld=0.
  - Leave for RUN the cycle after pp_busy[bank_ptr] clears.
- DONE:
  - done_vld=1 and done_bid=bid for one cycle.
  - bank_ptr toggles.
  - Next state is IDLE.
- Segment decode from g:
  - g ≤ DELTA: MID0.
  - DELTA+1 ≤ g ≤ 2S-DELTA-2: MID1.
  - g ≥ 2S-DELTA-1: MID2.
- cmd_stage = (g < S) ? S-1-g : g.
  - With the defaults, steps run stage 7,6,5,4 | 3,2,1,0,8,9,10,11 | 12,13,14,15.
- cmd_pp = bank_ptr when the segment is MID1, else 0.
- cmd_first: g=0 and beat=0. cmd_last: g=2S-1 and beat=BEAT_NB-1.
- pp_busy:
  - Set pp_busy[bank_ptr] on the first MID1 fire.
  - pp_release[b] clears pp_busy[b].
  - If set and release hit the same bank in the same cycle, set wins.
  - A release for a bank that is not busy is ignored.
- The pp_busy check happens only at the MID1 entry boundary. MID0 beats of a new batch proceed while its bank is still busy.

## Timing
- Reset values:
  - FSM=IDLE, g=0, beat=0, bank_ptr=0, pp_busy=0.
  - batch_rdy=1, cmd_vld=0, done_vld=0, busy=0.
  - All cmd_* fields 0, done_bid=0.
- A batch accepted at cycle t drives its first cmd_vld at t+1.
- With cmd_rdy held at 1 and no pp wait:
  - The last beat fires at t+2S·BEAT_NB.
  - done_vld is asserted at the next cycle.
  - batch_rdy returns the cycle after that.
- WAIT_PP costs at least 1 cycle. If pp_release arrives at cycle r, cmd_vld rises at r+2.
- Reset mid-batch: state returns to IDLE on the next edge, no done_vld, both pp_busy flags clear.

## Configuration
- HPU_PART_SCHED_PERF_EN defined: adds two outputs.
  - perf_stall_cnt[31:0]: cycles with cmd_vld && !cmd_rdy.
  - perf_pp_wait_cnt[31:0]: cycles in WAIT_PP.
  - Both saturate at 0xFFFFFFFF and clear on s_rst.
- Undefined: neither port nor counter exists; behaviour is otherwise identical.

## Test plan
- Nominal run, defaults, cmd_rdy=1, batch_id=5:
  - 64 beats on consecutive cycles.
  - cmd_stage sequence exactly as in Operation; seg pattern 4×0, 8×1, 4×2 steps.
  - cmd_pp=0; first/last flags on beats 0 and 63.
  - done_vld with done_bid=5 one cycle after beat 63.
- Backpressure: cmd_rdy toggled 1/0 every cycle.
  - 64 beats still delivered, with fields stable during stalls.
  - With PERF_EN: perf_stall_cnt=63.
- PP blocking: two back-to-back batches with no pp_release.
  - Batch 2 (cmd_pp=1) completes normally.
  - Batch 3 emits 16 MID0 beats, then enters WAIT_PP.
  - Pulse pp_release=2'b01 at cycle r: cmd_vld rises at r+2 with cmd_seg=1, cmd_stage=3, cmd_pp=0.
- Simultaneous set/release: pp_release[bank] pulsed in the cycle of the first MID1 fire -> pp_busy stays 1.
- Reset mid-batch: assert s_rst after beat 20.
  - Next cycle: cmd_vld=0, batch_rdy=1, no done_vld.
  - A new batch restarts at cmd_stage=7 with cmd_first=1.
- BEAT_NB=1, S=4, DELTA=2:
  - 8 beats with stages 3,2,1 | 0,4 | 5,6,7.
  - cmd_first and cmd_last both correct.
